// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: full-duplex serial shift sequencer with valid/ready word intake
// and a one-cycle done pulse that presents the received word.
`default_nettype none

module shift_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int DIV   = 1,
  localparam int CW   = $clog2(WIDTH) + 1,
  localparam int DW   = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] din,
  output logic             in_ready,
  input  logic             si,
  output logic             so,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] par_out,
  output logic [CW-1:0]    bit_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] par_q, par_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    div_q, div_d;
  logic [WIDTH-1:0] shifted;

  assign shifted = {si, shreg_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          shreg_d = din;
          cnt_d   = '0;
          div_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // si is sampled only on the last clock of each bit period
        if (div_q == DW'(DIV - 1)) begin
          div_d   = '0;
          shreg_d = shifted;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            par_d   = shifted;
            state_d = S_DONE;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      par_q   <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
    end
  end

  assign in_ready = (state_q == S_IDLE);
  assign busy     = (state_q == S_SHIFT) || (state_q == S_DONE);
  assign done     = (state_q == S_DONE);
  assign so       = shreg_q[0];
  assign par_out  = par_q;
  assign bit_cnt  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: directed bench for shift_seq_ctrl with three parameterisations
// (4/1, 4/3 and 8/2 with serial loopback) sharing one clock and reset.
`default_nettype none

module tb_shift_seq_ctrl;

  logic clk;
  logic clear;

  logic       in_valid_a, si_a, in_ready_a, so_a, busy_a, done_a;
  logic [3:0] din_a, par_a;
  logic [2:0] cnt_a;

  logic       in_valid_b, si_b, in_ready_b, so_b, busy_b, done_b;
  logic [3:0] din_b, par_b;
  logic [2:0] cnt_b;

  logic       in_valid_c, si_c, in_ready_c, so_c, busy_c, done_c;
  logic [7:0] din_c, par_c;
  logic [3:0] cnt_c;

  int cmp_cnt = 0;
  int err_cnt = 0;

  assign si_c = so_c;

  shift_seq_ctrl #(.WIDTH(4), .DIV(1)) u_a (
    .clk(clk), .clear(clear), .in_valid(in_valid_a), .din(din_a),
    .in_ready(in_ready_a), .si(si_a), .so(so_a), .busy(busy_a),
    .done(done_a), .par_out(par_a), .bit_cnt(cnt_a)
  );

  shift_seq_ctrl #(.WIDTH(4), .DIV(3)) u_b (
    .clk(clk), .clear(clear), .in_valid(in_valid_b), .din(din_b),
    .in_ready(in_ready_b), .si(si_b), .so(so_b), .busy(busy_b),
    .done(done_b), .par_out(par_b), .bit_cnt(cnt_b)
  );

  shift_seq_ctrl #(.WIDTH(8), .DIV(2)) u_c (
    .clk(clk), .clear(clear), .in_valid(in_valid_c), .din(din_c),
    .in_ready(in_ready_c), .si(si_c), .so(so_c), .busy(busy_c),
    .done(done_c), .par_out(par_c), .bit_cnt(cnt_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] w4;
    logic [3:0] sib;
    int p;

    clear = 1'b1;
    in_valid_a = 1'b0; din_a = '0; si_a = 1'b0;
    in_valid_b = 1'b0; din_b = '0; si_b = 1'b0;
    in_valid_c = 1'b0; din_c = '0;

    // Asynchronous reset with no clock edge in between
    #2 clear = 1'b0;
    #1;
    chk("rst_in_ready", in_ready_a, 1);
    chk("rst_so", so_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_par_out", par_a, 0);
    chk("rst_bit_cnt", cnt_a, 0);
    #4 clear = 1'b1;
    tick();

    // W=4 DIV=1, din=1011, si=1
    in_valid_a = 1'b1; din_a = 4'b1011; si_a = 1'b1;
    w4 = 4'b1011;
    tick();
    in_valid_a = 1'b0;
    chk("t2_busy", busy_a, 1);
    chk("t2_in_ready", in_ready_a, 0);
    for (int k = 0; k < 4; k++) begin
      chk("t2_so", so_a, w4[k]);
      chk("t2_bit_cnt", cnt_a, k);
      chk("t2_no_done", done_a, 0);
      tick();
    end
    chk("t2_done", done_a, 1);
    chk("t2_par_out", par_a, 4'b1111);
    chk("t2_cnt_full", cnt_a, 4);
    chk("t2_busy_done", busy_a, 1);
    tick();
    chk("t2_ready_again", in_ready_a, 1);
    chk("t2_done_drop", done_a, 0);
    chk("t2_par_hold", par_a, 4'b1111);
    chk("t2_cnt_zero", cnt_a, 0);

    // Reset mid-transfer, then a clean transfer
    in_valid_a = 1'b1; din_a = 4'b1101; si_a = 1'b0;
    tick();
    in_valid_a = 1'b0;
    chk("t5_busy", busy_a, 1);
    tick();
    clear = 1'b0;
    #1;
    chk("t5_rst_ready", in_ready_a, 1);
    chk("t5_rst_busy", busy_a, 0);
    chk("t5_rst_par", par_a, 0);
    chk("t5_rst_so", so_a, 0);
    chk("t5_rst_cnt", cnt_a, 0);
    tick();
    tick();
    chk("t5_no_done", done_a, 0);
    clear = 1'b1;
    in_valid_a = 1'b1; din_a = 4'b0110; si_a = 1'b1;
    w4 = 4'b0110;
    tick();
    in_valid_a = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t5_so", so_a, w4[k]);
      tick();
    end
    chk("t5_done", done_a, 1);
    chk("t5_par_out", par_a, 4'b1111);
    tick();
    chk("t5_ready", in_ready_a, 1);

    // W=4 DIV=3, din=0110, si per bit period 1,0,0,1
    in_valid_b = 1'b1; din_b = 4'b0110;
    w4 = 4'b0110;
    sib = 4'b1001;
    tick();
    in_valid_b = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      si_b = sib[(c-1)/3];
      chk("t3_so", so_b, w4[(c-1)/3]);
      chk("t3_bit_cnt", cnt_b, (c-1)/3);
      chk("t3_no_done", done_b, 0);
      tick();
    end
    chk("t3_done", done_b, 1);
    chk("t3_par_out", par_b, 4'b1001);
    chk("t3_cnt_full", cnt_b, 4);
    tick();
    chk("t3_ready", in_ready_b, 1);
    chk("t3_par_hold", par_b, 4'b1001);

    // in_valid held high with changing din; accepts only every 6 clocks
    in_valid_a = 1'b1; si_a = 1'b0;
    w4 = '0;
    for (int n = 0; n < 18; n++) begin
      din_a = 4'((n * 5) + 3);
      if ((n % 6) == 0) w4 = din_a;
      tick();
      p = n % 6;
      chk("t4_in_ready", in_ready_a, (p == 5) ? 1 : 0);
      chk("t4_done", done_a, (p == 4) ? 1 : 0);
      if (p <= 3) chk("t4_so", so_a, w4[p]);
      if (p == 4) chk("t4_par_out", par_a, 0);
    end
    in_valid_a = 1'b0;

    // W=8 DIV=2 with so looped back to si
    in_valid_c = 1'b1; din_c = 8'hA5;
    tick();
    in_valid_c = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      chk("t6_no_done", done_c, 0);
      chk("t6_bit_cnt", cnt_c, (c-1)/2);
      tick();
    end
    chk("t6_done", done_c, 1);
    chk("t6_par_out", par_c, 8'hA5);
    chk("t6_cnt_full", cnt_c, 8);
    tick();
    chk("t6_ready", in_ready_c, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Sequencer for a right-shift register (MSB-fill from serial input, LSB out) with one internal shift register.
- Accepts a parallel word over a valid/ready handshake, shifts it out LSB-first, one bit per DIV clocks.
- Simultaneously shifts in WIDTH bits from si, giving full-duplex serial exchange.
- Presents the received word with a one-cycle done pulse. Sits between a parallel producer/consumer and a serial link.

Parameters:
WIDTH, 4, shift register / word width in bits (>=2)
DIV, 1, clocks per bit period (>=1)

Ports:
clk  input  1  clock, all state updates on rising edge
clear  input  1  asynchronous active-low reset; clear=0 resets all state immediately
in_valid  input  1  producer offers din this cycle
din  input  WIDTH  parallel word to transmit
in_ready  output  1  block can accept a word (IDLE only)
si  input  1  serial input, shifted into MSB
so  output  1  serial output = shift register bit 0
busy  output  1  high in SHIFT and DONE states
done  output  1  one-cycle pulse, transfer complete
par_out  output  WIDTH  received word, valid when done=1, held until next accept
bit_cnt  output  clog2(WIDTH)+1  bits already shifted in current transfer

Behaviour:
- Reset (clear=0, asynchronous, dominates clk):
  - state=IDLE; shift register=0; so=0; in_ready=1; busy=0; done=0; par_out=0; bit_cnt=0; divider count=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - Accept on rising edge with in_valid=1: shift register<=din, bit_cnt<=0, div count<=0, go to SHIFT.
  - in_valid=0: stay in IDLE.
- SHIFT:
  - in_ready=0, busy=1; so=shreg[0] (combinational from register).
  - Div count runs 0..DIV-1. At count==DIV-1: shreg<={si, shreg[WIDTH-1:1]}, bit_cnt+1, div count<=0. Otherwise div count+1.
  - si is sampled only at that edge, i.e. at the end of each bit period.
  - When the shift that makes bit_cnt==WIDTH occurs: go to DONE.
- DONE (exactly one cycle):
  - done=1, busy=1, in_ready=0; par_out=shreg, which equals the WIDTH si samples, first sample at LSB.
  - Next edge: go to IDLE, bit_cnt<=0.
  - par_out retains its value until the next accept.
- Latency:
  - Accept edge = edge 0. Bit k of din is on so during clocks [1+k*DIV, (k+1)*DIV].
  - done is high in the cycle after edge WIDTH*DIV.
  - in_ready is high again one cycle later.
  - Back-to-back period = WIDTH*DIV + 2 clocks.
- Boundary conditions:
  - in_valid while busy: ignored; din not captured; no error flag.
  - in_valid held high in DONE: not accepted until IDLE, then accepted on the first IDLE edge.
  - DIV=1: shift on every SHIFT edge, div count constant 0.
  - bit_cnt never exceeds WIDTH; no wrap.
  - so in IDLE and DONE shows shreg[0]. It carries no meaning there; receivers must ignore it.
  - Reset mid-transfer: transfer abandoned, no done pulse, par_out=0, in_ready=1 after clear deasserts.
  - clear deasserted coincident with a clk edge: that edge has no effect.

Test Plan:
1. Reset: drive clear=0 mid-cycle without a clk edge -> all outputs at reset values immediately; in_ready=1, so=0, par_out=0.
2. WIDTH=4, DIV=1, din=4'b1011, si=1 constant -> so=1,1,0,1 on clocks 1-4; done=1 on clock 5 with par_out=4'b1111; in_ready=1 on clock 6.
3. WIDTH=4, DIV=3, din=4'b0110, si=1,0,0,1 applied per bit period -> each so bit held 3 clocks (0,1,1,0); done on clock 13 with par_out=4'b1001; bit_cnt steps 0→4 at edges 3,6,9,12.
4. in_valid held high continuously with alternating din -> accepts only at clocks 0, 6, 12 (DIV=1); mid-transfer din changes never appear on so.
5. Assert clear=0 at clock 2 of a transfer -> done never pulses, par_out=0; a new word is accepted on the first edge after clear=1 and transfers correctly.
6. WIDTH=8, DIV=2, din=8'hA5, si looped to so -> done on clock 17 with par_out=8'hA5.
